crc64_frame_ctrl: RTL

Frame-level sequencer for the serial CRC-64 datapath. It accepts parallel words from a requester over a valid/ready handshake and serialises each word MSB-first, one bit per clock, into an internal bit-serial CRC-64 LFSR. On the last word of a frame it registers the final CRC and pulses a completion strobe. It sits between a word-oriented producer and the bit-serial CRC engine, handling init, per-bit sequencing and result capture.

---
 rtl/crc64_frame_ctrl.sv | 129 ++++++++++++
 1 files changed

// File: rtl/crc64_frame_ctrl.sv
// Word-to-bit sequencer for a serial CRC-64 LFSR: one word per handshake, MSB first, WORD_W+1 cycles per word.
// Optional frame_len word counter is enabled by defining CRC_FRAME_LEN_EN.
module crc64_frame_ctrl #(
  parameter int          WORD_W = 8,
  parameter logic [63:0] POLY   = 64'h42F0E1EBA9EA3693,
  parameter logic [63:0] INIT   = 64'h0,
  parameter logic [63:0] XOROUT = 64'h0
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              start,
  input  logic              s_valid,
  input  logic [WORD_W-1:0] s_data,
  input  logic              s_last,
  output logic              s_ready,
  output logic              busy,
  output logic              crc_valid,
`ifdef CRC_FRAME_LEN_EN
  output logic [15:0]       frame_len,
`endif
  output logic [63:0]       CRC
);

  localparam int CNT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_SHIFT
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [63:0]       r_lfsr;
  logic [WORD_W-1:0] r_sh;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_last;
  logic [63:0]       r_crc;
  logic              r_crc_valid;

  logic              w_fb;
  logic [63:0]       w_lfsr_nxt;
  logic              w_final_bit;

  assign w_fb        = r_lfsr[63] ^ r_sh[WORD_W-1];
  assign w_lfsr_nxt  = {r_lfsr[62:0], 1'b0} ^ (w_fb ? POLY : 64'h0);
  assign w_final_bit = (r_cnt == '0);

  always_ff @(posedge CLK) begin
    if (RST) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    s_ready     = 1'b0;
    busy        = 1'b1;
    case (r_state)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) w_state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        s_ready = 1'b1;
        if (s_valid) w_state_nxt = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (w_final_bit) w_state_nxt = r_last ? ST_IDLE : ST_WAIT;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_lfsr      <= INIT;
      r_sh        <= '0;
      r_cnt       <= '0;
      r_last      <= 1'b0;
      r_crc       <= 64'h0;
      r_crc_valid <= 1'b0;
    end else begin
      r_crc_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) r_lfsr <= INIT;
        end
        ST_WAIT: begin
          if (s_valid) begin
            r_sh   <= s_data;
            r_last <= s_last;
            r_cnt  <= CNT_W'(WORD_W - 1);
          end
        end
        ST_SHIFT: begin
          r_lfsr <= w_lfsr_nxt;
          r_sh   <= r_sh << 1;
          if (!w_final_bit) r_cnt <= r_cnt - 1'b1;
          // The result is taken from the post-shift LFSR so the last bit is included.
          if (w_final_bit && r_last) begin
            r_crc       <= w_lfsr_nxt ^ XOROUT;
            r_crc_valid <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef CRC_FRAME_LEN_EN
  logic [15:0] r_frame_len;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_frame_len <= 16'h0;
    end else if (r_state == ST_IDLE && start) begin
      r_frame_len <= 16'h0;
    end else if (r_state == ST_WAIT && s_valid && r_frame_len != 16'hFFFF) begin
      r_frame_len <= r_frame_len + 16'h1;
    end
  end

  assign frame_len = r_frame_len;
`endif

  assign CRC       = r_crc;
  assign crc_valid = r_crc_valid;

endmodule
